// File: rtl/sync_fifo_flagged.sv
// Synchronous FIFO with registered occupancy flags, sticky overflow/underflow
// and a choice of first-word-fall-through or registered read data.
module sync_fifo_flagged #(
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 16,
   parameter int ALMOST_FULL  = 12,
   parameter int ALMOST_EMPTY = 2,
   parameter int FWFT         = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     w_en,
   input  logic [WIDTH-1:0]         i_dat,
   input  logic                     r_en,
   output logic [WIDTH-1:0]         o_dat,
   output logic                     o_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     w_full,
   output logic                     w_almost_full,
   output logic                     r_empty,
   output logic                     r_almost_empty,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
      $error("sync_fifo_flagged: DEPTH must be a power of 2 and at least 4");
   end
   if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_badAlmostFull
      $error("sync_fifo_flagged: ALMOST_FULL must lie in 1..DEPTH");
   end
   if (ALMOST_EMPTY < 0 || ALMOST_EMPTY > DEPTH - 1) begin : g_badAlmostEmpty
      $error("sync_fifo_flagged: ALMOST_EMPTY must lie in 0..DEPTH-1");
   end

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;
   logic [CW-1:0]    r_count;
   logic             w_wrAccept;
   logic             w_rdAccept;
   logic [CW-1:0]    w_countNext;

   // A write into a full FIFO is dropped even if a read frees a slot this cycle.
   assign w_wrAccept  = w_en & ~w_full & ~flush;
   assign w_rdAccept  = r_en & ~r_empty & ~flush;
   assign w_countNext = r_count + CW'(w_wrAccept) - CW'(w_rdAccept);
   assign count       = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr        <= '0;
         r_rdPtr        <= '0;
         r_count        <= '0;
         w_full         <= 1'b0;
         w_almost_full  <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_empty <= 1'b1;
         overflow       <= 1'b0;
         underflow      <= 1'b0;
      end else if (flush) begin
         r_wrPtr        <= '0;
         r_rdPtr        <= '0;
         r_count        <= '0;
         w_full         <= 1'b0;
         w_almost_full  <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_empty <= 1'b1;
         overflow       <= 1'b0;
         underflow      <= 1'b0;
      end else begin
         if (w_wrAccept) begin
            r_wrPtr <= r_wrPtr + (AW+1)'(1);
         end
         if (w_rdAccept) begin
            r_rdPtr <= r_rdPtr + (AW+1)'(1);
         end
         r_count        <= w_countNext;
         w_full         <= (w_countNext == CW'(DEPTH));
         w_almost_full  <= (w_countNext >= CW'(ALMOST_FULL));
         r_empty        <= (w_countNext == '0);
         r_almost_empty <= (w_countNext <= CW'(ALMOST_EMPTY));
         if (w_en && w_full) begin
            overflow <= 1'b1;
         end
         if (r_en && r_empty) begin
            underflow <= 1'b1;
         end
      end
   end

   // Storage is deliberately left unreset; only the pointers define contents.
   always_ff @(posedge clk) begin
      if (w_wrAccept) begin
         r_mem[r_wrPtr[AW-1:0]] <= i_dat;
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; zero while empty so reset presents 0.
      assign o_dat   = r_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
      assign o_valid = ~r_empty;
   end else begin : g_std
      logic [WIDTH-1:0] r_oDat;
      logic             r_oValid;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_oDat   <= '0;
            r_oValid <= 1'b0;
         end else if (flush) begin
            r_oValid <= 1'b0;
         end else begin
            r_oValid <= w_rdAccept;
            if (w_rdAccept) begin
               r_oDat <= r_mem[r_rdPtr[AW-1:0]];
            end
         end
      end

      assign o_dat   = r_oDat;
      assign o_valid = r_oValid;
   end

endmodule

// File: doc/sync_fifo_flagged.md
SYNC_FIFO_FLAGGED -- requirements
Module: sync_fifo_flagged

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 16: entry count; power of 2, at least 4.
REQ-003 Parameter ALMOST_FULL, default 12: occupancy threshold for w_almost_full; range 1..DEPTH.
REQ-004 Parameter ALMOST_EMPTY, default 2: occupancy threshold for r_almost_empty; range 0..DEPTH-1.
REQ-005 Parameter FWFT, default 1: 1 = first-word-fall-through read mode, 0 = registered standard read mode.
REQ-006 One clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  sole clock; all logic on rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 flush  input  1  synchronous clear of FIFO contents and sticky flags.
REQ-010 w_en  input  1  write request.
REQ-011 i_dat  input  WIDTH  write data.
REQ-012 r_en  input  1  read request / pop.
REQ-013 o_dat  output  WIDTH  read data.
REQ-014 o_valid  output  1  o_dat holds a valid popped/head word.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 w_full, w_almost_full, r_empty, r_almost_empty  output  1 each  registered status flags.
REQ-017 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 Write accepted iff w_en=1, w_full=0 and flush=0; word stored at write pointer, pointer advances by 1 modulo DEPTH.
REQ-019 Read accepted iff r_en=1, r_empty=0 and flush=0; read pointer advances by 1 modulo DEPTH.
REQ-020 Write while full is dropped: memory, pointers and count unchanged; no pass-through even if a read is accepted in the same cycle.
REQ-021 Simultaneous accepted write and read: count unchanged, both pointers advance.
REQ-022 count next = count + accepted_write - accepted_read; registered; never exceeds DEPTH nor goes below 0.
REQ-023 Flags registered from next count: w_full = (count==DEPTH); r_empty = (count==0); w_almost_full = (count >= ALMOST_FULL); r_almost_empty = (count <= ALMOST_EMPTY); all valid in the same cycle as count.
REQ-024 Pointers carry one extra wrap bit; full/empty derivation is consistent with count across any number of wrap-arounds.
REQ-025 FWFT=1: o_dat = memory[read pointer] combinationally; o_valid = !r_empty; accepted read presents next word the following cycle.
REQ-026 FWFT=0: on accepted read, o_dat registers memory[read pointer] and o_valid=1 next cycle (latency 1); otherwise o_valid=0 and o_dat holds its last value.
REQ-027 overflow set on cycle after w_en=1 with w_full=1; underflow set on cycle after r_en=1 with r_empty=1; both remain set until flush or rst.
REQ-028 flush=1: pointers and count go to 0, r_empty=1, r_almost_empty=1, w_full=0, w_almost_full=0, overflow=underflow=0, o_valid=0; w_en/r_en in that cycle ignored; memory contents not cleared.
REQ-029 Illegal parameter values (non-power-of-2 DEPTH, thresholds out of range) shall stop elaboration with an error.

Reset
REQ-030 rst=1 immediately forces: pointers=0, count=0, r_empty=1, r_almost_empty=1, w_full=0, w_almost_full=0, overflow=0, underflow=0, o_valid=0, o_dat=0.
REQ-031 Memory array is not reset; reset mid-operation discards all stored entries.
REQ-032 First write accepted on first rising edge with rst=0.

Verification (WIDTH=8, DEPTH=16, ALMOST_FULL=12, ALMOST_EMPTY=2)
REQ-033 Write 0x00..0x0F, no reads -> count 1..16; w_almost_full rises when count=12; w_full=1 at count=16; extra write of 0xAA dropped, overflow=1.
REQ-034 From full, read 16 words (FWFT=1) -> o_dat sequence 0x00..0x0F; r_almost_empty=1 at count=2; r_empty=1 at count=0; extra r_en sets underflow=1.
REQ-035 Continuous simultaneous write/read at count=8 for 40 cycles -> count stays 8, pointers wrap twice, data order preserved.
REQ-036 FWFT=0, write 0x5A then pulse r_en -> o_valid=1 and o_dat=0x5A exactly one cycle after r_en; o_valid=0 next cycle.
REQ-037 count=10 with overflow=1, assert flush with w_en=r_en=1 -> next cycle count=0, r_empty=1, overflow=0, no write stored.
REQ-038 Assert rst asynchronously mid-burst at count=7 -> all outputs take REQ-030 values before next clock edge; subsequent write of 0x33 read back as first word.
